// File: rtl/jt51_dac_rx.sv
`default_nettype none
// ============================================================================
// Module   : jt51_dac_rx
// Purpose  : Receiver for the JT51 serial DAC link. Deserialises the
//            YM3012-style floating-point words (3-bit exponent, 10-bit
//            two's-complement mantissa, SH1 = left, SH2 = right framing)
//            and expands them back to 16-bit signed linear PCM.
// Revision : 1.0  initial release
// ============================================================================
module jt51_dac_rx #(
  parameter int BITS      = 16,   // serial word length, 13..16
  parameter bit EXP0_ZERO = 1'b1  // 1: exponent 0 -> 0x0000, 0: treat as exponent 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_en,
  input  logic        so,
  input  logic        sh1,
  input  logic        sh2,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        left_vld,
  output logic        right_vld,
  output logic        frame_err
);

  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(BITS + 1);

  // Only the 13 most recently received bits matter: the dummy bits are sent
  // first and simply fall out of the bottom of the shift register.
  logic [12:0]   sr;
  logic [CW-1:0] cnt;
  logic          sh1_q;
  logic          sh2_q;
  logic          conflict;

  logic          end_l;
  logic          end_r;
  logic          any_end;
  logic          word_ok;
  logic [2:0]    exp_f;
  logic [9:0]    man;
  logic [2:0]    e_eff;
  logic [15:0]   man_ext;
  logic [15:0]   lin;

  assign end_l   = bit_en & sh1_q & ~sh1;
  assign end_r   = bit_en & sh2_q & ~sh2;
  assign any_end = end_l | end_r;
  assign word_ok = (cnt == CNT_FULL) & ~conflict;
  assign exp_f   = sr[12:10];
  assign man     = sr[9:0];

  // Floating-point to linear expansion of the word currently in the register
  always_comb begin
    e_eff   = (exp_f == 3'd0) ? 3'd1 : exp_f;
    man_ext = {{6{man[9]}}, man};
    lin     = man_ext << (e_eff - 3'd1);
    if ((exp_f == 3'd0) && EXP0_ZERO) begin
      lin = 16'h0000;
    end
  end

  // Serial capture: frame history, shift register, bit counter, conflict flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      cnt      <= '0;
      sh1_q    <= 1'b0;
      sh2_q    <= 1'b0;
      conflict <= 1'b0;
    end else if (bit_en) begin
      sh1_q <= sh1;
      sh2_q <= sh2;
      if (any_end) begin
        cnt      <= '0;
        conflict <= 1'b0;
      end else if (sh1 | sh2) begin
        sr <= {so, sr[12:1]};
        if (cnt != CNT_SAT) begin
          cnt <= cnt + 1'b1;
        end
        if (sh1 & sh2) begin
          conflict <= 1'b1;
        end
      end
    end
  end

  // Output latch at frame end; pulses self-clear on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left      <= 16'h0000;
      right     <= 16'h0000;
      left_vld  <= 1'b0;
      right_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      left_vld  <= 1'b0;
      right_vld <= 1'b0;
      frame_err <= 1'b0;
      if (end_l & end_r) begin
        // both frames closing together is ambiguous: drop the word
        frame_err <= 1'b1;
      end else if (end_l) begin
        if (word_ok) begin
          left     <= lin;
          left_vld <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (end_r) begin
        if (word_ok) begin
          right     <= lin;
          right_vld <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
